// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes and FSM states.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WRITE  = 2'b10,
    ST_RESP   = 2'b11
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: load extract/extend and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] ins_data;

  always_comb begin
    shamt     = {offset, 3'b000};
    shifted   = rd_word >> shamt;
    load_data = shifted;
    lane_mask = 32'hFFFF_FFFF;
    case (size)
      SZ_BYTE: begin
        load_data = is_unsigned ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        lane_mask = 32'h0000_00FF << shamt;
      end
      SZ_HALF: begin
        load_data = is_unsigned ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        lane_mask = 32'h0000_FFFF << shamt;
      end
      default: ;
    endcase
    // Store data arrives right-justified; move it up to the addressed lane.
    ins_data = wdata << shamt;
    merged   = (rd_word & ~lane_mask) | (ins_data & lane_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator with read-modify-write for sub-word stores.
// Optional saturating statistics counters are built when LSU_STATS_EN is defined.
//
// state  | meaning
// IDLE   | ready for a request; checks size/alignment/range on accept
// ACCESS | memory read (loads, SB/SH) or direct word write (SW)
// WRITE  | writes the merged word for SB/SH
// RESP   | response held until resp_ready
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_BITS = 14,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_wr_en,
  input  logic [31:0]       mem_rdata,
  output logic [STAT_W-1:0] stat_loads,
  output logic [STAT_W-1:0] stat_stores,
  output logic [STAT_W-1:0] stat_errors
);

  lsu_state_t  state;
  logic        op_we;
  logic        op_unsigned;
  logic [1:0]  op_size;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [31:0] merged_q;
  logic [31:0] load_data;
  logic [31:0] merged_d;
  logic        req_err;
  logic        direct_write;

  lsu_lane_align u_align (
    .rd_word     (mem_rdata),
    .offset      (op_addr[1:0]),
    .size        (op_size),
    .is_unsigned (op_unsigned),
    .wdata       (op_wdata),
    .load_data   (load_data),
    .merged      (merged_d)
  );

  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11)                          req_err = 1'b1;
    if ((req_addr >> ADDR_BITS) != 32'd0)           req_err = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])         req_err = 1'b1;
  end

  // SW needs no read, so it writes straight out of ACCESS.
  assign direct_write = (state == ST_ACCESS) && op_we && (op_size == SZ_WORD);

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign mem_addr   = (state == ST_ACCESS || state == ST_WRITE) ? {op_addr[31:2], 2'b00} : 32'd0;
  assign mem_wdata  = (state == ST_WRITE) ? merged_q : (direct_write ? op_wdata : 32'd0);
  assign mem_wr_en  = !reset && ((state == ST_WRITE) || direct_write);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      op_we       <= 1'b0;
      op_unsigned <= 1'b0;
      op_size     <= 2'b00;
      op_addr     <= 32'd0;
      op_wdata    <= 32'd0;
      merged_q    <= 32'd0;
      resp_rdata  <= 32'd0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_we       <= req_we;
            op_unsigned <= req_unsigned;
            op_size     <= req_size;
            op_addr     <= req_addr;
            op_wdata    <= req_wdata;
            resp_rdata  <= 32'd0;
            resp_err    <= req_err;
            state       <= req_err ? ST_RESP : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!op_we) begin
            resp_rdata <= load_data;
            state      <= ST_RESP;
          end else if (op_size == SZ_WORD) begin
            state <= ST_RESP;
          end else begin
            merged_q <= merged_d;
            state    <= ST_WRITE;
          end
        end
        ST_WRITE: state <= ST_RESP;
        ST_RESP:  if (resp_ready) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef LSU_STATS_EN
  logic resp_done;
  assign resp_done = (state == ST_RESP) && resp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errors <= '0;
    end else if (resp_done) begin
      if (resp_err) begin
        if (stat_errors != '1) stat_errors <= stat_errors + STAT_W'(1);
      end else if (op_we) begin
        if (stat_stores != '1) stat_stores <= stat_stores + STAT_W'(1);
      end else begin
        if (stat_loads != '1) stat_loads <= stat_loads + STAT_W'(1);
      end
    end
  end
`else
  assign stat_loads  = '0;
  assign stat_stores = '0;
  assign stat_errors = '0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-level memory reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr_en;
  logic [31:0] mem_rdata;
  logic [15:0] stat_loads, stat_stores, stat_errors;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata),
    .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errors(stat_errors)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT, and the model's own independent copy.
  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  assign mem_rdata = mem[mem_addr[13:2]];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr[13:2]] <= mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Expectation of the outstanding request and what the monitor observed.
  logic        exp_err;
  logic [31:0] exp_rdata;
  int          exp_lat, exp_wr;
  bit          pending = 0, seen_resp = 0, done = 0;
  int          cyc = 0, wr_cnt = 0;
  logic [31:0] last_rdata;
  logic        last_err;
  int          last_lat;
  int          m_loads = 0, m_stores = 0, m_errors = 0;

  function automatic void model_req(input logic we, input logic [1:0] size, input logic uns,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    output logic e, output logic [31:0] rd, output int lat, output int wr);
    int nb, off;
    logic [31:0] w;
    logic [11:0] idx;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    e   = (size == 2'd3) || (addr >= 32'h4000) || ((addr % nb) != 0);
    rd  = 32'd0;
    wr  = 0;
    lat = 1;
    if (!e) begin
      idx = addr[13:2];
      off = int'(addr % 4);
      if (!we) begin
        w = ref_mem[idx];
        for (int i = 0; i < nb; i++) rd[8*i +: 8] = w[8*(off+i) +: 8];
        if (!uns && nb < 4 && rd[8*nb-1])
          for (int i = nb; i < 4; i++) rd[8*i +: 8] = 8'hFF;
        lat = 2;
      end else begin
        for (int i = 0; i < nb; i++) ref_mem[idx][8*(off+i) +: 8] = wdata[8*i +: 8];
        wr  = 1;
        lat = (nb == 4) ? 2 : 3;
      end
    end
  endfunction

  // Per-cycle compare process.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("mem_addr_align_range", {mem_addr[31:14], 12'd0, mem_addr[1:0]}, 32'd0);
      if (pending) begin
        cyc++;
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        if (mem_wr_en) wr_cnt++;
        if (resp_valid) begin
          if (!seen_resp) begin
            seen_resp  = 1;
            last_rdata = resp_rdata;
            last_err   = resp_err;
            last_lat   = cyc;
            chk("latency", 32'(cyc), 32'(exp_lat));
          end
          chk("resp_rdata", resp_rdata, exp_rdata);
          chk("resp_err", 32'(resp_err), 32'(exp_err));
          chk("mem_idle_in_resp", mem_addr | mem_wdata | 32'(mem_wr_en), 32'd0);
          if (resp_ready) begin
            chk("mem_write_count", 32'(wr_cnt), 32'(exp_wr));
            pending = 0;
            done    = 1;
          end
        end
      end else if (req_ready) begin
        chk("idle_outputs", {31'd0, resp_valid} | mem_addr | mem_wdata | 32'(mem_wr_en), 32'd0);
      end
    end
  end

  task automatic check_stats();
`ifdef LSU_STATS_EN
    chk("stat_loads",  32'(stat_loads),  32'(m_loads));
    chk("stat_stores", 32'(stat_stores), 32'(m_stores));
    chk("stat_errors", 32'(stat_errors), 32'(m_errors));
`else
    chk("stat_tied_zero", 32'(stat_loads | stat_stores | stat_errors), 32'd0);
`endif
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_loads = 0; m_stores = 0; m_errors = 0;
    pending = 0;
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    int guard;
    model_req(we, size, uns, addr, wdata, exp_err, exp_rdata, exp_lat, exp_wr);
    @(posedge clk); #1;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = $urandom_range(0, 1); req_size = 2'($urandom_range(0, 3));
    req_addr = $urandom(); req_wdata = $urandom();
    cyc = 0; wr_cnt = 0; seen_resp = 0; done = 0; pending = 1;
    if (hold > 0) begin
      guard = 0;
      while (!seen_resp && guard < 20) begin @(posedge clk); guard++; end
      repeat (hold) @(posedge clk);
      #1 resp_ready = 1'b1;
    end
    guard = 0;
    while (!done && guard < 50) begin @(posedge clk); guard++; end
    if (!done) begin
      chk("response_timeout", 32'd0, 32'd1);
      do_reset();
    end else begin
      if (exp_err) m_errors++;
      else if (we) m_stores++;
      else m_loads++;
      #1;
      if (we && !exp_err) chk("mem_word", mem[addr[13:2]], ref_mem[addr[13:2]]);
      check_stats();
    end
  endtask

  initial begin
    int hold;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = $urandom();
      ref_mem[i] = mem[i];
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp", {31'd0, resp_valid} | resp_rdata | 32'(resp_err), 32'd0);
    chk("rst_mem", mem_addr | mem_wdata | 32'(mem_wr_en), 32'd0);
    chk("rst_stats", 32'(stat_loads | stat_stores | stat_errors), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Directed sequence with literal expectations
    do_req(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 0);
    chk("sw_mem", mem[12'h040], 32'hDEADBEEF);
    chk("sw_rdata_zero", last_rdata, 32'd0);
    do_req(0, 2'b10, 0, 32'h100, 32'd0, 0);
    chk("lw_lit", last_rdata, 32'hDEADBEEF);
    chk("lw_lat", 32'(last_lat), 32'd2);
    do_req(0, 2'b00, 0, 32'h101, 32'd0, 0);
    chk("lb_lit", last_rdata, 32'hFFFFFFBE);
    do_req(0, 2'b00, 1, 32'h101, 32'd0, 0);
    chk("lbu_lit", last_rdata, 32'h000000BE);
    do_req(0, 2'b01, 0, 32'h102, 32'd0, 0);
    chk("lh_lit", last_rdata, 32'hFFFFDEAD);
    do_req(0, 2'b01, 1, 32'h102, 32'd0, 0);
    chk("lhu_lit", last_rdata, 32'h0000DEAD);
    do_req(1, 2'b00, 0, 32'h103, 32'h00000012, 0);
    chk("sb_mem_lit", mem[12'h040], 32'h12ADBEEF);
    chk("sb_lat", 32'(last_lat), 32'd3);
    chk("sb_err", 32'(last_err), 32'd0);

    do_req(0, 2'b10, 0, 32'h102, 32'd0, 0);
    chk("err_lw_misal", {31'd0, last_err} | 32'(last_lat << 4), 32'h11);
    do_req(1, 2'b01, 0, 32'h101, 32'hFFFF, 0);
    chk("err_sh_misal", {31'd0, last_err} | 32'(last_lat << 4), 32'h11);
    do_req(0, 2'b10, 0, 32'h4000, 32'd0, 0);
    chk("err_range", {31'd0, last_err} | 32'(last_lat << 4), 32'h11);
    do_req(0, 2'b11, 0, 32'h0, 32'd0, 0);
    chk("err_size", {31'd0, last_err} | 32'(last_lat << 4), 32'h11);

    do_req(0, 2'b10, 0, 32'h100, 32'd0, 5);
    chk("hold_lw", last_rdata, 32'h12ADBEEF);

    // Reset while in WRITE abandons the store.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h203; req_wdata = 32'hA5;
    resp_ready = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    chk("write_state_wr_en", 32'(mem_wr_en), 32'd1);
    reset = 1'b1;
    #1 chk("wr_en_gated_by_reset", 32'(mem_wr_en), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    m_loads = 0; m_stores = 0; m_errors = 0;
    chk("rst_abandon_mem", mem[12'h080], ref_mem[12'h080]);
    chk("rst_abandon_valid", 32'(resp_valid), 32'd0);
    chk("rst_abandon_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("rst_abandon_valid2", 32'(resp_valid), 32'd0);

    // Statistics pin: 2 loads, 1 store, 1 error after reset
    do_req(0, 2'b10, 0, 32'h10, 32'd0, 0);
    do_req(0, 2'b00, 1, 32'h11, 32'd0, 0);
    do_req(1, 2'b01, 0, 32'h20, 32'h1234, 0);
    do_req(0, 2'b01, 0, 32'h21, 32'd0, 0);
`ifdef LSU_STATS_EN
    chk("stats_pin", {8'd0, stat_loads[7:0], stat_stores[7:0], stat_errors[7:0]}, 32'h00020101);
`else
    chk("stats_pin", 32'(stat_loads | stat_stores | stat_errors), 32'd0);
`endif

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      sz = ($urandom_range(0, 7) == 7) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) a = $urandom() | 32'h4000;
      else a = 32'($urandom_range(0, 16383));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(), hold);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
